// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and defaults for the parametrised inter-stage register.
// Default widths match the original EXE/MEM bundle:
//   control = {wb_en, mem_read_en, mem_write_en}
//   data    = {alu_res[31:0], val_Rm[31:0], dest[3:0]}
package pipe_pkg;

  // Occupancy of the two-entry (primary + skid) buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  localparam int CTRL_W_DEF = 3;
  localparam int DATA_W_DEF = 68;

  // Value the control bundle takes when no beat is presented (a bubble).
  localparam logic [CTRL_W_DEF-1:0] CTRL_ZERO = '0;

endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: skid entry and occupancy FSM for the two-entry buffer mode.
// Instantiated by pipe_stage_reg only when PIPE_SKID_EN is defined. It tells the
// top when to load the primary register from the input or from the skid entry.
// It also produces the registered ready, which keeps out_ready out of the in_ready path.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic              accept,
  input  logic              handoff,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              prim_vld,
  output logic              ready_q,
  output logic              prim_ld_in,
  output logic              prim_ld_skid,
  output logic [CTRL_W-1:0] skid_ctrl,
  output logic [DATA_W-1:0] skid_data
);

  occ_e occ, occ_nxt;
  logic skid_ld;

  assign prim_vld = (occ != EMPTY);

  // Next occupancy and load steering; flush empties, freeze holds everything.
  always_comb begin
    occ_nxt      = occ;
    prim_ld_in   = 1'b0;
    prim_ld_skid = 1'b0;
    skid_ld      = 1'b0;
    if (flush) begin
      occ_nxt = EMPTY;
    end else if (!freeze) begin
      case (occ)
        EMPTY: begin
          if (accept) begin
            occ_nxt    = ONE;
            prim_ld_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && !handoff) begin
            occ_nxt = TWO;
            skid_ld = 1'b1;
          end else if (accept && handoff) begin
            prim_ld_in = 1'b1;
          end else if (handoff) begin
            occ_nxt = EMPTY;
          end
        end
        TWO: begin
          if (handoff) begin
            occ_nxt      = ONE;
            prim_ld_skid = 1'b1;
          end
        end
        default: occ_nxt = EMPTY;
      endcase
    end
  end

  // Occupancy state and registered ready (ready whenever the next state is not full).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ     <= EMPTY;
      ready_q <= 1'b0;
    end else begin
      occ     <= occ_nxt;
      ready_q <= (occ_nxt != TWO);
    end
  end

  // Skid entry: captures the beat that arrives while the primary is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (flush) begin
      skid_ctrl <= '0;
    end else if (skid_ld) begin
      skid_ctrl <= in_ctrl;
      skid_data <= in_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register with valid/ready,
// freeze (hold) and flush (bubble insert), plus a saturating back-pressure counter.
// Optional build macro PIPE_SKID_EN: adds a skid entry (pipe_skid_buf) so that
// in_ready is registered and does not depend combinationally on out_ready.
// Without the macro the stage holds a single entry.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic              vld_p1;
  logic [CTRL_W-1:0] ctrl_p1;
  logic [DATA_W-1:0] data_p1;
  logic              accept;
  logic              handoff;

  // A beat shown during a flush cycle can still leave; freeze alone hides it.
  assign out_valid = vld_p1 && (flush || !freeze);
  assign handoff   = out_valid && out_ready;
  assign accept    = in_valid && in_ready;
  assign out_ctrl  = out_valid ? ctrl_p1 : CTRL_W'(CTRL_ZERO);
  assign out_data  = data_p1;

`ifdef PIPE_SKID_EN
  logic              ready_q;
  logic              prim_ld_in;
  logic              prim_ld_skid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  assign in_ready = ready_q && !freeze && !flush;

  pipe_skid_buf #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .freeze       (freeze),
    .accept       (accept),
    .handoff      (handoff),
    .in_ctrl      (in_ctrl),
    .in_data      (in_data),
    .prim_vld     (vld_p1),
    .ready_q      (ready_q),
    .prim_ld_in   (prim_ld_in),
    .prim_ld_skid (prim_ld_skid),
    .skid_ctrl    (skid_ctrl),
    .skid_data    (skid_data)
  );

  // Stage p1 (primary): loaded from the input or refilled from the skid entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_p1 <= '0;
      data_p1 <= '0;
    end else if (flush) begin
      ctrl_p1 <= '0;
    end else if (prim_ld_in) begin
      ctrl_p1 <= in_ctrl;
      data_p1 <= in_data;
    end else if (prim_ld_skid) begin
      ctrl_p1 <= skid_ctrl;
      data_p1 <= skid_data;
    end
  end
`else
  // A full entry can still accept when it is handed off in the same cycle.
  assign in_ready = !freeze && !flush && (!vld_p1 || out_ready);

  // Stage p1 (single entry): replace on accept, empty on handoff alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
      data_p1 <= '0;
    end else if (flush) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
    end else if (!freeze) begin
      if (accept) begin
        vld_p1  <= 1'b1;
        ctrl_p1 <= in_ctrl;
        data_p1 <= in_data;
      end else if (handoff) begin
        vld_p1 <= 1'b0;
      end
    end
  end
`endif

  // Count cycles where a presented beat is refused downstream; only reset clears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule
